can_tx_frame_seq: RTL
=====================

// Module: can_tx_frame_seq
// PURPOSE
//  Sequences one CAN 2.0A (11-bit ID) transmit frame, one bit per bit_tick_i, unstuffed.
//  Fields are sent in order: SOF, arbitration, control, data, CRC, delimiters, EOF, IFS.
//  Owns the can_crc instance: feeds it SOF..DATA, then serialises the 15-bit CRC.
//  Sits between the frame request logic and the bit stuffer / bit-timing block.
// PARAMETERS
//  MAX_BYTES  8  data bytes sent at most; the DLC field value is sent as-is.
// PORTS
//  clk_can_i    in   1   CAN core clock; the only clock.
//  rst_i        in   1   Synchronous, active-high reset.
//  bit_tick_i   in   1   One-cycle strobe per nominal bit time.
//  start_i      in   1   Frame request; accepted only in IDLE.
//  abort_i      in   1   Abandons the frame immediately (arbitration loss or error).
//  id_i         in   11  Identifier, sent MSB first.
//  rtr_i        in   1   Remote frame: 0 data bytes.
//  dlc_i        in   4   Data length code.
//  data_i       in   64  Payload. Byte0 = [63:56], sent first, MSB first.
//  busy_o       out  1   High from start acceptance until done_o.
//  done_o       out  1   One-cycle pulse when the frame completes.
//  tx_bit_o     out  1   Current bit level; 1 = recessive.
//  stuff_en_o   out  1   High while the current bit lies in SOF..last CRC bit.
//  crc_o        out  15  Final CRC; held from entering CRC until the next start.
// BEHAVIOUR
//  Reset: state IDLE. tx_bit_o=1, busy_o=0, done_o=0, stuff_en_o=0, crc_o=0.
//  The internal CRC is cleared.
//  Start: start_i in IDLE latches id, rtr, dlc and data.
//  - nbytes = rtr ? 0 : min(dlc, MAX_BYTES).
//  - busy_o goes 1 next cycle; a 1-cycle crc_rst pulse is issued.
//  - start_i while busy_o=1 is ignored.
//  Bit issue: on each bit_tick_i with busy_o=1, the next bit b is computed combinationally.
//  - tx_bit_o <= b, so it is registered and valid 1 cycle after the tick.
//  - During SOF..DATA, can_crc sees en_i=1 and data_i=b in that same cycle.
//  - bit_tick_i in the same cycle as start acceptance issues no bit; SOF goes on the next tick.
//  States, with bit counts (6-bit counter, reloaded on each state entry):
//  - IDLE
//  - SOF(1)=0
//  - ARB(12) = id[10:0], rtr
//  - CTRL(6) = IDE=0, r0=0, dlc[3:0]
//  - DATA(8*nbytes); skipped when nbytes=0
//  - CRC(15): crc[14] first, from a snapshot taken on entry
//  - CRCDEL(1)=1, ACK(1)=1, ACKDEL(1)=1, EOF(7)=1, IFS(3)=1
//  Frame length is 44+8*nbytes bits, plus 3 IFS bits.
//  Completion: done_o pulses and busy_o drops 1 cycle after the tick that issues the 3rd IFS bit.
//  Control: stuff_en_o tracks the bit just issued; it is 1 for SOF..CRC and 0 from CRCDEL on.
//  Abort: abort_i goes to IDLE on the next edge, from any state.
//  - tx_bit_o=1, stuff_en_o=0, no done_o.
//  - The CRC is cleared; crc_o keeps its last value.
//  - abort_i has priority over bit_tick_i and start_i.
//  Priority: rst_i > abort_i > bit_tick_i > start_i.
//  A reset mid-frame returns every output to its reset value.
//  dlc > 8 sends the raw DLC but only 8 bytes.
// STRUCTURE
//  Shared can_pkg: state encoding and field widths.
//  - CAN_ID_W=11, CAN_CRC_W=15, CAN_EOF_LEN=7, CAN_IFS_LEN=3
//  - CAN_RECESSIVE=1'b1
//  Sub-module: can_crc, instanced once.
//  - Its rst_i = ~rst_i.
//  - Its crc_rst_i = registered start/abort pulse.
//  - Its en_i and data_i come from the bit-issue logic.
//  Rest: one FSM, a bit counter, a byte/bit index into the latched data, and a CRC shift register.
// TESTING
//  Single frame: id=0, rtr=0, dlc=0, ticks every 4 clk.
//  - Exactly 44 frame bits, all 0 up to the CRC field.
//  - crc_o=0x0000, then 10 recessive bits, 3 IFS bits, one done_o pulse.
//  Full payload: id=0x123, dlc=8, data=0x0011223344556677.
//  - Bit count is 108+3.
//  - The tx_bit_o stream matches a software model.
//  - crc_o matches the model's CRC-15 (poly 0x4599) over SOF..DATA.
//  RTR and oversize DLC:
//  - rtr=1, dlc=8: no DATA bits, 44+3 bits.
//  - rtr=0, dlc=15: DLC field sent as 1111, 64 data bits.
//  Abort: abort_i at the 5th DATA bit.
//  - Next cycle busy_o=0, tx_bit_o=1, no done_o.
//  - A new start then produces a correct CRC (internal CRC was cleared).
//  Start while busy is ignored, with no glitch on tx_bit_o.
//  Start coincident with bit_tick_i: SOF appears on the following tick.
//  Reset mid-CRC: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions: field widths, bit levels and the transmit sequencer state encoding.
package can_pkg;

  localparam int unsigned CAN_ID_W     = 11;
  localparam int unsigned CAN_CRC_W    = 15;
  localparam int unsigned CAN_EOF_LEN  = 7;
  localparam int unsigned CAN_IFS_LEN  = 3;
  localparam int unsigned CAN_ARB_LEN  = CAN_ID_W + 1;
  localparam int unsigned CAN_CTRL_LEN = 6;

  localparam logic                 CAN_RECESSIVE = 1'b1;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY  = 15'h4599;

  typedef enum logic [3:0] {
    StIdle,
    StSof,
    StArb,
    StCtrl,
    StData,
    StCrc,
    StCrcDel,
    StAck,
    StAckDel,
    StEof,
    StIfs
  } can_tx_state_e;

  // Bit-counter reload value on entry to a field; DATA is counted by the data index instead.
  function automatic logic [5:0] field_len(can_tx_state_e st);
    logic [5:0] len;
    case (st)
      StSof, StCrcDel, StAck, StAckDel: len = 6'd1;
      StArb:                            len = 6'(CAN_ARB_LEN);
      StCtrl:                           len = 6'(CAN_CTRL_LEN);
      StCrc:                            len = 6'(CAN_CRC_W);
      StEof:                            len = 6'(CAN_EOF_LEN);
      StIfs:                            len = 6'(CAN_IFS_LEN);
      default:                          len = 6'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/can_crc.sv
// Serial CAN CRC-15 accumulator; one bit per enabled cycle, synchronous clear.
module can_crc
  import can_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 crc_rst_i,
  input  logic                 en_i,
  input  logic                 data_i,
  output logic [CAN_CRC_W-1:0] crc_o
);

  logic [CAN_CRC_W-1:0] crc_d, crc_q;
  logic                 fb;

  always_comb begin
    crc_d = crc_q;
    fb    = data_i ^ crc_q[CAN_CRC_W-1];
    // Clear wins over a coincident SOF bit; a 0 bit into a zero CRC leaves it zero anyway.
    if (crc_rst_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[CAN_CRC_W-2:0], 1'b0} ^ (fb ? CAN_CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_tx_frame_seq.sv
// CAN 2.0A transmit frame sequencer: issues one unstuffed frame bit per bit tick, SOF to IFS.
module can_tx_frame_seq
  import can_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8
) (
  input  logic                 clk_can_i,
  input  logic                 rst_i,
  input  logic                 bit_tick_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CAN_ID_W-1:0]  id_i,
  input  logic                 rtr_i,
  input  logic [3:0]           dlc_i,
  input  logic [63:0]          data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tx_bit_o,
  output logic                 stuff_en_o,
  output logic [CAN_CRC_W-1:0] crc_o
);

  can_tx_state_e        state_d, state_q, state_nxt;
  logic [5:0]           cnt_d, cnt_q, data_idx_d, data_idx_q;
  logic [CAN_ID_W-1:0]  id_d, id_q;
  logic                 rtr_d, rtr_q;
  logic [3:0]           dlc_d, dlc_q, nbytes_d, nbytes_q;
  logic [63:0]          data_d, data_q;
  logic [CAN_CRC_W-1:0] crc_sh_d, crc_sh_q, crc_hold_d, crc_hold_q, crc_val, crc_src;
  logic                 tx_bit_d, tx_bit_q, stuff_en_d, stuff_en_q;
  logic                 done_d, done_q, crc_rst_d, crc_rst_q;

  logic                 start_acc, issue, bit_b, crc_en, in_stuff, field_last, data_last;
  logic [3:0]           cnt_idx;
  logic [6:0]           data_bits;
  logic [11:0]          arb_vec;
  logic [5:0]           ctrl_vec;

  assign start_acc = start_i && (state_q == StIdle);
  assign issue     = bit_tick_i && (state_q != StIdle);
  assign cnt_idx   = cnt_q[3:0] - 4'd1;
  assign data_bits = {nbytes_q, 3'b000};
  assign data_last = ({1'b0, data_idx_q} == (data_bits - 7'd1));
  assign arb_vec   = {id_q, rtr_q};
  assign ctrl_vec  = {1'b0, 1'b0, dlc_q};
  // The first CRC bit reads the accumulator directly so back-to-back ticks still see it final.
  assign crc_src   = (cnt_q == 6'(CAN_CRC_W)) ? crc_val : crc_sh_q;

  can_crc u_can_crc (
    .clk_i     (clk_can_i),
    .rst_ni    (~rst_i),
    .crc_rst_i (crc_rst_q),
    .en_i      (crc_en),
    .data_i    (bit_b),
    .crc_o     (crc_val)
  );

  // State register
  always_ff @(posedge clk_can_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    unique case (state_q)
      StSof:    state_nxt = StArb;
      StArb:    state_nxt = StCtrl;
      StCtrl:   state_nxt = (nbytes_q == 4'd0) ? StCrc : StData;
      StData:   state_nxt = StCrc;
      StCrc:    state_nxt = StCrcDel;
      StCrcDel: state_nxt = StAck;
      StAck:    state_nxt = StAckDel;
      StAckDel: state_nxt = StEof;
      StEof:    state_nxt = StIfs;
      default:  state_nxt = StIdle;
    endcase
    state_d = state_q;
    if (abort_i) begin
      state_d = StIdle;
    end else if (issue && field_last) begin
      state_d = state_nxt;
    end else if (start_acc) begin
      state_d = StSof;
    end
  end

  // Output logic: the bit to issue for the current field position
  always_comb begin
    bit_b      = CAN_RECESSIVE;
    in_stuff   = 1'b0;
    crc_en     = 1'b0;
    field_last = (cnt_q == 6'd1);
    unique case (state_q)
      StSof:   begin bit_b = 1'b0;                     in_stuff = 1'b1; crc_en = issue; end
      StArb:   begin bit_b = arb_vec[cnt_idx];         in_stuff = 1'b1; crc_en = issue; end
      StCtrl:  begin bit_b = ctrl_vec[cnt_idx[2:0]];   in_stuff = 1'b1; crc_en = issue; end
      StData: begin
        bit_b      = data_q[~data_idx_q];
        in_stuff   = 1'b1;
        crc_en     = issue;
        field_last = data_last;
      end
      StCrc:   begin bit_b = crc_src[CAN_CRC_W-1];     in_stuff = 1'b1; end
      default: ;
    endcase
    if (abort_i) begin
      crc_en = 1'b0;
    end
  end

  // Datapath next-state
  always_comb begin
    cnt_d      = cnt_q;
    data_idx_d = data_idx_q;
    id_d       = id_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    nbytes_d   = nbytes_q;
    crc_sh_d   = crc_sh_q;
    crc_hold_d = crc_hold_q;
    tx_bit_d   = tx_bit_q;
    stuff_en_d = stuff_en_q;
    done_d     = 1'b0;
    crc_rst_d  = abort_i || start_acc;
    if (abort_i) begin
      tx_bit_d   = CAN_RECESSIVE;
      stuff_en_d = 1'b0;
    end else if (issue) begin
      tx_bit_d   = bit_b;
      stuff_en_d = in_stuff;
      if (state_q == StData) begin
        data_idx_d = data_idx_q + 6'd1;
      end else begin
        cnt_d = cnt_q - 6'd1;
      end
      if (state_q == StCrc) begin
        crc_sh_d = {crc_src[CAN_CRC_W-2:0], 1'b0};
      end
      if (field_last) begin
        cnt_d      = field_len(state_nxt);
        data_idx_d = '0;
        done_d     = (state_q == StIfs);
      end
    end else if (start_acc) begin
      cnt_d      = field_len(StSof);
      data_idx_d = '0;
      id_d       = id_i;
      rtr_d      = rtr_i;
      dlc_d      = dlc_i;
      data_d     = data_i;
      nbytes_d   = rtr_i ? 4'd0 : ((dlc_i > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc_i);
    end
    if (!abort_i && (state_q == StCrc) && (cnt_q == 6'(CAN_CRC_W))) begin
      crc_hold_d = crc_val;
    end
  end

  always_ff @(posedge clk_can_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      data_idx_q <= '0;
      id_q       <= '0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      nbytes_q   <= '0;
      crc_sh_q   <= '0;
      crc_hold_q <= '0;
      tx_bit_q   <= CAN_RECESSIVE;
      stuff_en_q <= 1'b0;
      done_q     <= 1'b0;
      crc_rst_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      data_idx_q <= data_idx_d;
      id_q       <= id_d;
      rtr_q      <= rtr_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      nbytes_q   <= nbytes_d;
      crc_sh_q   <= crc_sh_d;
      crc_hold_q <= crc_hold_d;
      tx_bit_q   <= tx_bit_d;
      stuff_en_q <= stuff_en_d;
      done_q     <= done_d;
      crc_rst_q  <= crc_rst_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign tx_bit_o   = tx_bit_q;
  assign stuff_en_o = stuff_en_q;
  assign crc_o      = crc_hold_q;

endmodule
